// File: rtl/sram_arb_pkg.sv
// Shared sizes and FSM state type for the 256x288 SRAM arbiter.
package sram_arb_pkg;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;
    localparam int LANES  = 32;
    localparam int LANE_W = 9;
    localparam int DATA_W = LANES * LANE_W;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/sram_256x288_arbiter_if.sv
// Requester-side request channel: valid/ready handshake carrying one masked access.
interface sram_256x288_arbiter_if;
    import sram_arb_pkg::*;

    logic              valid;
    logic              ready;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [LANES-1:0]  wmask;

    modport master (output valid, write, addr, wdata, wmask, input ready);
    modport slave  (input valid, write, addr, wdata, wmask, output ready);

endinterface

// File: rtl/sram_arb_rr2.sv
// Two-way round-robin arbiter; the preference pointer moves only when a grant is taken.
module sram_arb_rr2 (
    input  logic       clock,
    input  logic       resetn,
    input  logic       enable,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic prefer_b_q, prefer_b_d;

    // NOTE: every output and next-state gets a default first, so no path infers a latch.
    always_comb begin
        grant      = 2'b00;
        prefer_b_d = prefer_b_q;
        if (enable) begin
            if (req == 2'b11) begin
                grant = prefer_b_q ? 2'b10 : 2'b01;
            end else begin
                grant = req;
            end
        end
        // ready equals grant and grant implies valid, so any grant is an accepted transfer
        if (grant[0]) begin
            prefer_b_d = 1'b1;
        end else if (grant[1]) begin
            prefer_b_d = 1'b0;
        end
    end

    // NOTE: flops use non-blocking assignments so all of them sample pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            prefer_b_q <= 1'b0;
        end else begin
            prefer_b_q <= prefer_b_d;
        end
    end

endmodule

// File: rtl/sram_256x288_arbiter.sv
// Two-requester front end for a 256x288 masked single-port SRAM, with optional
// fill of every line after reset before any request is accepted.
module sram_256x288_arbiter
    import sram_arb_pkg::*;
#(
    parameter bit                INIT_ON_RESET = 1'b1,
    parameter logic [DATA_W-1:0] INIT_VALUE    = {DATA_W{1'b0}}
) (
    input  logic                  clock,
    input  logic                  resetn,
    sram_256x288_arbiter_if.slave a_if,
    sram_256x288_arbiter_if.slave b_if,
    output logic                  rsp_valid,
    output logic                  rsp_id,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  init_done,
    output logic                  sram_valid,
    output logic                  sram_write,
    output logic [ADDR_W-1:0]     sram_addr,
    output logic [DATA_W-1:0]     sram_wdata,
    output logic [LANES-1:0]      sram_wmask,
    input  logic [DATA_W-1:0]     sram_rdata
);

    localparam arb_state_e        RESET_STATE = INIT_ON_RESET ? ST_INIT : ST_RUN;
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              init_done_q, init_done_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q, rsp_id_d;
    logic [1:0]        grant;
    logic              run_en;

    // Held-low reset must silence the combinational handshake and SRAM strobes too,
    // including the INIT_ON_RESET=0 case where the reset state is already RUN.
    assign run_en = resetn && (state_q == ST_RUN);

    sram_arb_rr2 u_rr2 (
        .clock  (clock),
        .resetn (resetn),
        .enable (run_en),
        .req    ({b_if.valid, a_if.valid}),
        .grant  (grant)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        a_if.ready  = grant[0];
        b_if.ready  = grant[1];
        sram_valid  = 1'b0;
        sram_write  = 1'b0;
        sram_addr   = '0;
        sram_wdata  = '0;
        sram_wmask  = '0;

        unique case (state_q)
            ST_INIT: begin
                sram_valid = resetn;
                sram_write = 1'b1;
                sram_addr  = cnt_q;
                sram_wdata = INIT_VALUE;
                sram_wmask = '1;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (grant != 2'b00) begin
                    sram_valid  = 1'b1;
                    sram_write  = grant[1] ? b_if.write : a_if.write;
                    sram_addr   = grant[1] ? b_if.addr  : a_if.addr;
                    sram_wdata  = grant[1] ? b_if.wdata : a_if.wdata;
                    sram_wmask  = grant[1] ? b_if.wmask : a_if.wmask;
                    rsp_valid_d = !sram_write;
                    rsp_id_d    = grant[1];
                end
            end
        endcase

        // RUN is never left without a reset, so this is sticky until then.
        init_done_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= RESET_STATE;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_rdata = sram_rdata;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_sram_256x288_arbiter.sv
// Self-checking bench: behavioural SRAM macro, reference memory and a response
// scoreboard queue filled when reads are accepted and drained when responses appear.
module tb_sram_256x288_arbiter;
    import sram_arb_pkg::*;

    typedef struct packed {
        logic              valid;
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [LANES-1:0]  wmask;
    } req_t;

    typedef struct packed {
        logic              id;
        logic [DATA_W-1:0] data;
    } rsp_t;

    logic              clock = 1'b0;
    logic              resetn = 1'b0;
    logic              rsp_valid, rsp_id, init_done;
    logic [DATA_W-1:0] rsp_rdata;
    logic              sram_valid, sram_write;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [LANES-1:0]  sram_wmask;
    logic [DATA_W-1:0] sram_rdata;

    sram_256x288_arbiter_if a_if ();
    sram_256x288_arbiter_if b_if ();

    always #5 clock = ~clock;

    sram_256x288_arbiter dut (
        .clock      (clock),
        .resetn     (resetn),
        .a_if       (a_if),
        .b_if       (b_if),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_rdata  (rsp_rdata),
        .init_done  (init_done),
        .sram_valid (sram_valid),
        .sram_write (sram_write),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_wmask (sram_wmask),
        .sram_rdata (sram_rdata)
    );

    // Behavioural model of the masked single-port macro: read data one cycle after access.
    logic [DATA_W-1:0] sram_mem [DEPTH];
    logic [DATA_W-1:0] sram_word;
    always @(posedge clock) begin
        if (sram_valid) begin
            if (sram_write) begin
                sram_word = sram_mem[sram_addr];
                for (int l = 0; l < LANES; l++) begin
                    if (sram_wmask[l]) sram_word[l*LANE_W +: LANE_W] = sram_wdata[l*LANE_W +: LANE_W];
                end
                sram_mem[sram_addr] <= sram_word;
            end else begin
                sram_rdata <= sram_mem[sram_addr];
            end
        end
    end

    logic [DATA_W-1:0] exp_mem [DEPTH];
    rsp_t              exp_q [$];
    logic              prefer_b;
    int                n_checks = 0;
    int                n_fail   = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] d;
        for (int k = 0; k < DATA_W / 32; k++) d[k*32 +: 32] = $urandom();
        return d;
    endfunction

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                                input logic [DATA_W-1:0] new_w,
                                                input logic [LANES-1:0]  mask);
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int l = 0; l < LANES; l++) begin
            if (mask[l]) r[l*LANE_W +: LANE_W] = new_w[l*LANE_W +: LANE_W];
        end
        return r;
    endfunction

    function automatic req_t rd(input logic [ADDR_W-1:0] addr);
        req_t r;
        r = '0;
        r.valid = 1'b1;
        r.addr  = addr;
        return r;
    endfunction

    function automatic req_t wr(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                                input logic [LANES-1:0] mask);
        req_t r;
        r.valid = 1'b1;
        r.write = 1'b1;
        r.addr  = addr;
        r.wdata = data;
        r.wmask = mask;
        return r;
    endfunction

    function automatic req_t idle_req();
        req_t r;
        r = '0;
        return r;
    endfunction

    task automatic apply(input req_t ra, input req_t rb);
        a_if.valid = ra.valid; a_if.write = ra.write; a_if.addr = ra.addr;
        a_if.wdata = ra.wdata; a_if.wmask = ra.wmask;
        b_if.valid = rb.valid; b_if.write = rb.write; b_if.addr = rb.addr;
        b_if.wdata = rb.wdata; b_if.wmask = rb.wmask;
    endtask

    // Advance one clock and score whatever response the previous cycle owed.
    task automatic tick();
        rsp_t e;
        @(posedge clock);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rsp_valid", rsp_valid, 1'b1);
            check("rsp_id", rsp_id, e.id);
            check("rsp_rdata", rsp_rdata, e.data);
        end else begin
            check("rsp_idle", rsp_valid, 1'b0);
        end
    endtask

    // One RUN cycle: drive both requesters, predict the grant, check the SRAM side.
    task automatic access(input req_t ra, input req_t rb);
        logic ga, gb;
        req_t g;
        rsp_t r;
        apply(ra, rb);
        #1;
        ga = ra.valid && (!rb.valid || !prefer_b);
        gb = rb.valid && !ga;
        check("a_ready", a_if.ready, ga);
        check("b_ready", b_if.ready, gb);
        check("sram_valid", sram_valid, ga || gb);
        if (ga || gb) begin
            g = ga ? ra : rb;
            check("sram_write", sram_write, g.write);
            check("sram_addr", sram_addr, g.addr);
            prefer_b = ga;
            if (g.write) begin
                check("sram_wdata", sram_wdata, g.wdata);
                check("sram_wmask", sram_wmask, g.wmask);
                exp_mem[g.addr] = merge(exp_mem[g.addr], g.wdata, g.wmask);
            end else begin
                r.id   = gb;
                r.data = exp_mem[g.addr];
                exp_q.push_back(r);
            end
        end
        tick();
    endtask

    // Release reset and follow the fill; optionally re-assert reset at a given address.
    task automatic run_init(input int abort_at);
        exp_q.delete();
        prefer_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
        apply(rd(8'h01), rd(8'h02));
        @(posedge clock);
        #1;
        resetn = 1'b1;
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            check("init_ctl",
                  {sram_valid, sram_write, a_if.ready, b_if.ready, init_done, rsp_valid, sram_wmask, sram_addr},
                  {6'b110000, 32'hFFFF_FFFF, 8'(i)});
            check("init_wdata", sram_wdata, '0);
            if (i == abort_at) begin
                resetn = 1'b0;
                #1;
                check("abort_clear",
                      {sram_valid, a_if.ready, b_if.ready, init_done, rsp_valid, rsp_id}, 6'b0);
                return;
            end
            tick();
        end
        apply(idle_req(), idle_req());
        #1;
        check("init_done", init_done, 1'b1);
        check("run_idle_sram", sram_valid, 1'b0);
    endtask

    logic [DATA_W-1:0] p, q;
    req_t              ra, rb;

    initial begin
        apply(idle_req(), idle_req());
        prefer_b = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", {init_done, rsp_valid, rsp_id, sram_valid, a_if.ready}, 5'b0);
        run_init(-1);

        // both requesters reading every cycle: grants alternate starting with a
        for (int i = 0; i < 8; i++) begin
            check("rr_pointer", prefer_b, (i % 2) == 1);
            access(rd(8'h78 + 8'(i)), rd(8'h70 + 8'(i)));
        end
        access(rd(8'h7F), idle_req());
        access(idle_req(), idle_req());

        p = rand_data();
        access(wr(8'h10, p, '1), idle_req());
        access(rd(8'h10), idle_req());
        access(idle_req(), idle_req());

        p = rand_data();
        q = rand_data();
        access(wr(8'h20, p, '1), idle_req());
        access(wr(8'h20, q, 32'h0000_0001), idle_req());
        access(rd(8'h20), idle_req());
        check("lane_merge_model", exp_mem[8'h20], {p[DATA_W-1:LANE_W], q[LANE_W-1:0]});
        access(idle_req(), idle_req());

        p = rand_data();
        access(idle_req(), wr(8'h40, p, '1));
        access(idle_req(), wr(8'h40, rand_data(), '0));
        access(idle_req(), rd(8'h40));
        access(idle_req(), idle_req());

        for (int i = 0; i < 60; i++) begin
            ra = ($urandom_range(0, 1) == 1) ? rd(8'h30 + 8'($urandom_range(0, 7)))
                 : wr(8'h30 + 8'($urandom_range(0, 7)), rand_data(),
                      ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom());
            rb = ($urandom_range(0, 1) == 1) ? rd(8'h30 + 8'($urandom_range(0, 7)))
                 : wr(8'h30 + 8'($urandom_range(0, 7)), rand_data(), $urandom());
            ra.valid = ($urandom_range(0, 3) != 0);
            rb.valid = ($urandom_range(0, 3) != 0);
            access(ra, rb);
        end
        access(idle_req(), idle_req());

        // read accepted right before reset: its response must never appear
        apply(rd(8'h10), idle_req());
        #1;
        check("pre_reset_ready", a_if.ready, 1'b1);
        @(posedge clock);
        #1;
        resetn = 1'b0;
        #1;
        check("pre_reset_rsp", rsp_valid, 1'b0);
        apply(idle_req(), idle_req());
        @(posedge clock);
        #1;
        check("reset_rsp_held", rsp_valid, 1'b0);
        run_init(-1);

        // reset in the middle of the fill, then a full restart from address 0
        resetn = 1'b0;
        @(posedge clock);
        run_init(100);
        run_init(-1);
        access(rd(8'h10), idle_req());
        access(idle_req(), idle_req());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
